// File: rtl/mfp_ahb_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// mfp_ahb_uart_tx_pkg
// Shared constants for the AHB-lite UART transmitter slave: the system decode
// value for the new HSEL bit, the register word offsets, the BAUDDIV reset
// value, the transmitter state encoding and the effective-divisor helper.
// -----------------------------------------------------------------------------
package mfp_ahb_uart_tx_pkg;

   // The system decoder compares HADDR[31:4] with this value to drive HSEL.
   localparam logic [27:0] H_UART_ADDR_Match = 28'h1f8_0100;

   // Register word offsets (bus HADDR[3:2]).
   localparam logic [1:0] UART_TXDATA  = 2'd0;
   localparam logic [1:0] UART_STATUS  = 2'd1;
   localparam logic [1:0] UART_BAUDDIV = 2'd2;
   localparam logic [1:0] UART_CTRL    = 2'd3;

   // 115200 baud from a 50 MHz HCLK.
   localparam int unsigned MFP_UART_DIV_RESET = 434;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;

   // A divisor below 2 is kept in BAUDDIV as written but clocked as 2.
   function automatic logic [15:0] uart_eff_div(input logic [15:0] div);
      return (div < 16'd2) ? 16'd2 : div;
   endfunction

endpackage

// File: rtl/mfp_uart_fifo.sv
// -----------------------------------------------------------------------------
// mfp_uart_fifo
// Show-ahead synchronous FIFO for the UART transmitter.
//   HCLK, rstn : clock, synchronous active-low reset
//   push, din  : write din when not full (ignored during a flush)
//   pop        : drop the head entry when not empty
//   flush      : empty the FIFO this cycle
//   full, empty, count : occupancy (count runs 0..DEPTH)
//   dout       : head entry, valid while not empty
// -----------------------------------------------------------------------------
module mfp_uart_fifo #(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     HCLK,
   input  logic                     rstn,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [7:0]               din,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [7:0]               dout
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full & ~flush;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge HCLK) begin
      if (!rstn || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // NOTE: the storage array has no reset; an entry is only ever read after it
   // was written, so resetting it would only cost a wide reset fan-out.
   always_ff @(posedge HCLK) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mfp_ahb_uart_tx.sv
// -----------------------------------------------------------------------------
// mfp_ahb_uart_tx
// AHB-lite slave that queues bytes in a TX FIFO and sends them as 8N1 frames.
//   HCLK, rstn : bus clock, synchronous active-low reset
//   HADDR      : register word offset (bus HADDR[3:2])
//   HTRANS     : transfer type, HTRANS[1] marks an active transfer
//   HWRITE     : write flag (address phase); HWDATA : write data (data phase)
//   HSEL       : slave select (address phase)
//   HRDATA     : registered read data, valid in the data phase
//   UART_TX    : serial line, idle high
//   IRQ        : level interrupt, irq_en & FIFO empty & transmitter idle
// Registers: 0 TXDATA (wo), 1 STATUS (ro), 2 BAUDDIV, 3 CTRL.
// -----------------------------------------------------------------------------
module mfp_ahb_uart_tx
   import mfp_ahb_uart_tx_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned DIV_RESET  = MFP_UART_DIV_RESET
) (
   input  logic        HCLK,
   input  logic        rstn,
   input  logic [1:0]  HADDR,
   input  logic [1:0]  HTRANS,
   input  logic [31:0] HWDATA,
   input  logic        HWRITE,
   input  logic        HSEL,
   output logic [31:0] HRDATA,
   output logic        UART_TX,
   output logic        IRQ
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic          access, wr_pend;
   logic [1:0]    wr_addr;
   logic [15:0]   bauddiv;
   logic          tx_en, irq_en, overflow;
   logic          push, pop, flush, ovf_clr;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [7:0]    fifo_dout;
   logic [31:0]   rd_mux;
   logic          unused_bus;

   uart_state_e   state, state_n;
   logic [15:0]   bit_cnt, bit_cnt_n, div_eff, div_eff_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shreg, shreg_n;
   logic          busy, bit_last, start_ok, tx_bit;

   assign unused_bus = ^{HTRANS[0], HWDATA[31:16]};

   // Write decode happens in the data phase, using the latched address.
   assign access  = HSEL & HTRANS[1];
   assign push    = wr_pend & (wr_addr == UART_TXDATA);
   assign flush   = wr_pend & (wr_addr == UART_CTRL) & HWDATA[2];
   assign ovf_clr = wr_pend & (wr_addr == UART_CTRL) & HWDATA[3];

   mfp_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .HCLK  (HCLK),
      .rstn  (rstn),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (HWDATA[7:0]),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count),
      .dout  (fifo_dout)
   );

   assign busy     = (state != UART_IDLE);
   assign bit_last = (bit_cnt == div_eff - 16'd1);
   assign start_ok = tx_en & ~fifo_empty;

   // Read data comes from pre-edge state, so a read right behind a write
   // returns the value from before that write.
   always_comb begin
      rd_mux = '0;
      case (HADDR)
         UART_STATUS:  rd_mux = {23'd0, 5'(fifo_count), overflow, busy, fifo_empty, fifo_full};
         UART_BAUDDIV: rd_mux = {16'd0, bauddiv};
         UART_CTRL:    rd_mux = {30'd0, irq_en, tx_en};
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!rstn) begin
         wr_pend  <= 1'b0;
         wr_addr  <= '0;
         HRDATA   <= '0;
         bauddiv  <= 16'(DIV_RESET);
         tx_en    <= 1'b0;
         irq_en   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         wr_pend <= access & HWRITE;
         wr_addr <= HADDR;
         if (access && !HWRITE) HRDATA <= rd_mux;
         if (wr_pend) begin
            case (wr_addr)
               UART_BAUDDIV: bauddiv <= HWDATA[15:0];
               UART_CTRL: begin
                  tx_en  <= HWDATA[0];
                  irq_en <= HWDATA[1];
               end
               default: ;
            endcase
         end
         // A dropped push still counts as overflow even if a pop frees a slot.
         if (push && fifo_full) overflow <= 1'b1;
         else if (ovf_clr)      overflow <= 1'b0;
      end
   end

   // Transmitter: each state lasts div_eff cycles per bit; the divisor is
   // captured only when a frame starts, so BAUDDIV writes affect the next frame.
   always_ff @(posedge HCLK) begin
      if (!rstn) begin
         state   <= UART_IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         div_eff <= uart_eff_div(16'(DIV_RESET));
         UART_TX <= 1'b1;
         IRQ     <= 1'b0;
      end else begin
         state   <= state_n;
         bit_cnt <= bit_cnt_n;
         bit_idx <= bit_idx_n;
         shreg   <= shreg_n;
         div_eff <= div_eff_n;
         UART_TX <= tx_bit;
         IRQ     <= irq_en & fifo_empty & ~busy;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt + 16'd1;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      div_eff_n = div_eff;
      pop       = 1'b0;
      tx_bit    = 1'b1;
      unique case (state)
         UART_IDLE: begin
            bit_cnt_n = '0;
            if (start_ok) begin
               pop       = 1'b1;
               shreg_n   = fifo_dout;
               div_eff_n = uart_eff_div(bauddiv);
               state_n   = UART_START;
            end
         end
         UART_START: begin
            tx_bit = 1'b0;
            if (bit_last) begin
               bit_cnt_n = '0;
               bit_idx_n = '0;
               state_n   = UART_DATA;
            end
         end
         UART_DATA: begin
            tx_bit = shreg[0];
            if (bit_last) begin
               bit_cnt_n = '0;
               shreg_n   = {1'b0, shreg[7:1]};
               if (bit_idx == 3'd7) state_n   = UART_STOP;
               else                 bit_idx_n = bit_idx + 3'd1;
            end
         end
         UART_STOP: begin
            if (bit_last) begin
               bit_cnt_n = '0;
               // Chain straight into the next start bit when more data waits.
               if (start_ok) begin
                  pop       = 1'b1;
                  shreg_n   = fifo_dout;
                  div_eff_n = uart_eff_div(bauddiv);
                  state_n   = UART_START;
               end else begin
                  state_n   = UART_IDLE;
               end
            end
         end
         default: state_n = UART_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_mfp_ahb_uart_tx
// Self-checking bench for mfp_ahb_uart_tx. A frame-level model (byte queue,
// register copies, frame start time and divisor) predicts UART_TX, IRQ and
// read data every cycle; directed steps pin the model with literal values and
// a randomized phase exercises the rest.
// -----------------------------------------------------------------------------
module tb_mfp_ahb_uart_tx;

   localparam int DEPTH = 16;

   logic        HCLK = 1'b0;
   logic        rstn = 1'b0;
   logic [1:0]  HADDR = '0;
   logic [1:0]  HTRANS = '0;
   logic [31:0] HWDATA = '0;
   logic        HWRITE = 1'b0;
   logic        HSEL = 1'b0;
   logic [31:0] HRDATA;
   logic        UART_TX;
   logic        IRQ;

   mfp_ahb_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(434)) dut (
      .HCLK    (HCLK),
      .rstn    (rstn),
      .HADDR   (HADDR),
      .HTRANS  (HTRANS),
      .HWDATA  (HWDATA),
      .HWRITE  (HWRITE),
      .HSEL    (HSEL),
      .HRDATA  (HRDATA),
      .UART_TX (UART_TX),
      .IRQ     (IRQ)
   );

   always #10 HCLK = ~HCLK;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge HCLK) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]  m_q[$];
   logic        m_ovf, m_tx_en, m_irq_en, m_wr_pend;
   logic [15:0] m_baud;
   logic [1:0]  m_wr_addr;
   bit          m_active;
   int          m_pos, m_div;
   logic [9:0]  m_frame;
   logic        exp_line, exp_irq;
   logic [31:0] exp_hrdata;
   bit          exp_rd_valid;
   bit          model_ok = 1'b0;

   function automatic logic [31:0] m_read(input logic [1:0] a);
      logic [31:0] r;
      int n;
      r = '0;
      n = m_q.size();
      case (a)
         2'd1: begin
            r[0]   = (n == DEPTH);
            r[1]   = (n == 0);
            r[2]   = m_active;
            r[3]   = m_ovf;
            r[8:4] = 5'(n);
         end
         2'd2: r[15:0] = m_baud;
         2'd3: begin
            r[0] = m_tx_en;
            r[1] = m_irq_en;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // A frame is 10 bit slots of m_div cycles: slot 0 start (0), slots 1..8
   // data LSB first, slot 9 stop (1). The line flop shows the pre-edge slot.
   always @(posedge HCLK) begin : model_p
      bit pre_full;
      logic [7:0] b;
      if (!rstn) begin
         m_q.delete();
         m_ovf = 0; m_tx_en = 0; m_irq_en = 0; m_wr_pend = 0; m_wr_addr = '0;
         m_baud = 16'd434; m_active = 0; m_pos = 0; m_div = 2; m_frame = '0;
         exp_line = 1'b1; exp_irq = 1'b0; exp_rd_valid = 0; exp_hrdata = '0;
         model_ok = 1'b1;
      end else begin
         exp_line     = m_active ? m_frame[m_pos / m_div] : 1'b1;
         exp_irq      = m_irq_en && (m_q.size() == 0) && !m_active;
         exp_rd_valid = HSEL && HTRANS[1] && !HWRITE;
         if (exp_rd_valid) exp_hrdata = m_read(HADDR);
         pre_full = (m_q.size() == DEPTH);
         if (!m_active || m_pos == 10 * m_div - 1) begin
            if (m_tx_en && m_q.size() > 0) begin
               b        = m_q.pop_front();
               m_frame  = {1'b1, b, 1'b0};
               m_div    = (m_baud < 16'd2) ? 2 : int'(m_baud);
               m_pos    = 0;
               m_active = 1;
            end else begin
               m_active = 0;
            end
         end else begin
            m_pos++;
         end
         if (m_wr_pend) begin
            case (m_wr_addr)
               2'd0: if (pre_full) m_ovf = 1'b1; else m_q.push_back(HWDATA[7:0]);
               2'd2: m_baud = HWDATA[15:0];
               2'd3: begin
                  m_tx_en  = HWDATA[0];
                  m_irq_en = HWDATA[1];
                  if (HWDATA[2]) m_q.delete();
                  if (HWDATA[3]) m_ovf = 1'b0;
               end
               default: ;
            endcase
         end
         m_wr_pend = HSEL && HTRANS[1] && HWRITE;
         m_wr_addr = HADDR;
      end
   end

   // Compare process: outputs sampled on the falling edge.
   always @(negedge HCLK) begin
      if (model_ok) begin
         check("uart_tx", UART_TX, exp_line);
         check("irq", IRQ, exp_irq);
         if (exp_rd_valid) check("hrdata", HRDATA, exp_hrdata);
      end
   end

   // ---------------- bus tasks ----------------
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00;
      d = HRDATA;
   endtask

   // Write immediately followed by a read in the write's data phase.
   task automatic bus_wr_rd(input logic [1:0] wa, input logic [31:0] wd,
                            input logic [1:0] ra, output logic [31:0] d);
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = wa;
      @(negedge HCLK);
      HWRITE = 1'b0; HADDR = ra; HWDATA = wd;
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00;
      d = HRDATA;
   endtask

   // Finds a start bit, then samples each bit mid-slot.
   task automatic capture_frame(input int div, output logic [7:0] b, output int t0);
      bit found;
      found = 0;
      b = '0;
      t0 = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge HCLK);
         if (UART_TX === 1'b0) begin
            found = 1;
            break;
         end
      end
      check("frame_start_seen", found, 1);
      if (found) begin
         t0 = cyc;
         repeat (div / 2) @(negedge HCLK);
         check("start_bit_mid", UART_TX, 0);
         for (int k = 0; k < 8; k++) begin
            repeat (div) @(negedge HCLK);
            b[k] = UART_TX;
         end
         repeat (div) @(negedge HCLK);
         check("stop_bit_mid", UART_TX, 1);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] d;
      logic [9:0]  seq55;
      logic [7:0]  b1, b2;
      int          t1, t2, op;

      repeat (3) @(negedge HCLK);
      rstn = 1'b1;

      // 1: reset state
      check("reset_uart_tx", UART_TX, 1);
      check("reset_irq", IRQ, 0);
      bus_read(2'd1, d); check("reset_status", d, 32'h002);
      bus_read(2'd2, d); check("reset_bauddiv", d, 32'd434);
      bus_read(2'd0, d); check("txdata_reads_zero", d, 32'd0);

      // 2: single 0x55 frame at divisor 4; write-then-read sees old value
      bus_wr_rd(2'd2, 32'd4, 2'd2, d); check("read_after_write_old", d, 32'd434);
      bus_read(2'd2, d); check("bauddiv_written", d, 32'd4);
      bus_write(2'd3, 32'h1);
      bus_write(2'd0, 32'h55);
      seq55 = 10'b1010101010;
      @(negedge HCLK);
      @(negedge HCLK);
      check("line_high_after_e1", UART_TX, 1);
      for (int k = 0; k < 40; k++) begin
         @(negedge HCLK);
         check("frame55_bit", UART_TX, {31'd0, seq55[k / 4]});
      end
      @(negedge HCLK);
      check("idle_after_frame55", UART_TX, 1);
      bus_read(2'd1, d); check("status_after_frame55", d, 32'h002);

      // 3: fill past full with transmitter disabled
      bus_write(2'd3, 32'h0);
      for (int i = 0; i < 17; i++) bus_write(2'd0, i);
      bus_read(2'd1, d); check("status_full_ovf", d, 32'h109);
      bus_write(2'd3, 32'h8);
      bus_read(2'd1, d); check("status_ovf_cleared", d, 32'h101);

      // 4: back-to-back frames
      bus_write(2'd3, 32'h4);
      bus_read(2'd1, d); check("status_flushed", d, 32'h002);
      bus_write(2'd0, 32'hA5);
      bus_write(2'd0, 32'h3C);
      bus_write(2'd3, 32'h1);
      capture_frame(4, b1, t1);
      capture_frame(4, b2, t2);
      check("frame1_byte", b1, 8'hA5);
      check("frame2_byte", b2, 8'h3C);
      check("no_gap_cycles", t2 - t1, 40);

      // 5: flush mid-frame
      bus_write(2'd0, 32'h11);
      bus_write(2'd0, 32'h22);
      bus_write(2'd0, 32'h33);
      repeat (10) @(negedge HCLK);
      bus_write(2'd3, 32'h5);
      repeat (60) @(negedge HCLK);
      bus_read(2'd1, d); check("status_after_flush", d, 32'h002);

      // divisor 1 is stored as written but clocked as 2
      bus_write(2'd2, 32'd1);
      bus_read(2'd2, d); check("bauddiv_one_stored", d, 32'd1);
      bus_write(2'd0, 32'hC6);
      capture_frame(2, b1, t1);
      check("div1_frame_byte", b1, 8'hC6);

      // 6: interrupt timing, then reset mid-frame
      bus_write(2'd2, 32'd4);
      bus_write(2'd3, 32'h3);
      repeat (3) @(negedge HCLK);
      check("irq_idle_empty", IRQ, 1);
      bus_write(2'd0, 32'h5A);
      repeat (3) @(negedge HCLK);
      check("irq_low_busy", IRQ, 0);
      repeat (39) @(negedge HCLK);
      check("irq_low_last_cycle", IRQ, 0);
      @(negedge HCLK);
      check("irq_rises", IRQ, 1);
      bus_write(2'd0, 32'h0F);
      repeat (15) @(negedge HCLK);
      rstn = 1'b0;
      @(negedge HCLK);
      check("rst_uart_tx", UART_TX, 1);
      check("rst_irq", IRQ, 0);
      check("rst_hrdata", HRDATA, 0);
      rstn = 1'b1;
      bus_read(2'd1, d); check("rst_status", d, 32'h002);
      bus_read(2'd2, d); check("rst_bauddiv", d, 32'd434);
      bus_read(2'd3, d); check("rst_ctrl", d, 32'd0);

      // randomized phase, checked by the model every cycle
      bus_write(2'd2, $urandom_range(0, 5));
      for (int it = 0; it < 300; it++) begin
         op = $urandom_range(0, 11);
         case (op)
            0, 1, 2, 3, 11: bus_write(2'd0, $urandom);
            4: bus_write(2'd2, $urandom_range(0, 5));
            5: begin
               d = $urandom;
               d[0] = ($urandom_range(0, 3) != 0);
               d[1] = ($urandom_range(0, 1) != 0);
               d[2] = ($urandom_range(0, 7) == 0);
               d[3] = ($urandom_range(0, 3) == 0);
               bus_write(2'd3, d);
            end
            6: bus_read(2'($urandom_range(0, 3)), d);
            7: bus_wr_rd(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFF3, 2'($urandom_range(0, 3)), d);
            8: repeat ($urandom_range(1, 40)) @(negedge HCLK);
            9: begin
               @(negedge HCLK);
               if ($urandom_range(0, 1) == 0) begin
                  HSEL = 1'b0; HTRANS = 2'b10;
               end else begin
                  HSEL = 1'b1; HTRANS = 2'($urandom_range(0, 1));
               end
               HWRITE = 1'b1; HADDR = 2'($urandom_range(0, 3)); HWDATA = $urandom;
               @(negedge HCLK);
               HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
            end
            default: begin
               if ($urandom_range(0, 4) == 0) begin
                  @(negedge HCLK);
                  rstn = 1'b0;
                  @(negedge HCLK);
                  rstn = 1'b1;
                  bus_write(2'd2, $urandom_range(0, 5));
               end else begin
                  repeat (5) @(negedge HCLK);
               end
            end
         endcase
      end
      repeat (900) @(negedge HCLK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
